// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the FIFO blocks.
//   DEPTH_DEF / PTRWIDTH_DEF / DWIDTH_DEF : default geometry (16 x 8, 4-bit index)
//   ptr_t  : pointer with one extra wrap bit, at the default size
//   data_t : data word, at the default size
package fifo_pkg;

    localparam int DEPTH_DEF    = 16;
    localparam int PTRWIDTH_DEF = 4;
    localparam int DWIDTH_DEF   = 8;

    typedef logic [PTRWIDTH_DEF:0]  ptr_t;
    typedef logic [DWIDTH_DEF-1:0]  data_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DWIDTH register array, one synchronous write port and one
// synchronous read port. No reset; contents and read register power up unknown.
//   clk    : clock, rising edge
//   we     : write enable, waddr/wdata written on the edge
//   re     : read enable, rdata loads mem[raddr] on the edge, holds otherwise
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AWIDTH = PTRWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO, DEPTH entries of DWIDTH bits.
//   wclk, reset        : clock (rising edge), async active-high reset
//   push, wdata, full  : write side; write happens when push && !full
//   pop, rdata, empty  : read side; rdata is registered, valid one cycle after
//                        an accepted pop, and holds otherwise
//   count              : occupancy 0..DEPTH
//   overflow/underflow : one-cycle pulses after a rejected push/pop
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PTRWIDTH = PTRWIDTH_DEF,
    parameter int DWIDTH   = DWIDTH_DEF
) (
    input  logic                wclk,
    input  logic                reset,
    input  logic                push,
    input  logic [DWIDTH-1:0]   wdata,
    output logic                full,
    input  logic                pop,
    output logic [DWIDTH-1:0]   rdata,
    output logic                empty,
    output logic [PTRWIDTH:0]   count,
    output logic                overflow,
    output logic                underflow
);

    logic [PTRWIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTRWIDTH:0] rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_seen_q, rd_seen_d;
    logic              push_ok, pop_ok;
    logic [DWIDTH-1:0] mem_rdata;

    // Flags come straight from the registered pointers; the extra MSB tells
    // a full ring (indices equal, laps differ) from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTRWIDTH-1:0] == rd_ptr_q[PTRWIDTH-1:0]) &&
                   (wr_ptr_q[PTRWIDTH] != rd_ptr_q[PTRWIDTH]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_seen_d   = rd_seen_q;
        overflow_d  = push && full;
        underflow_d = pop && empty;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_seen_d = 1'b1;
        end
    end

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_seen_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_seen_q   <= rd_seen_d;
        end
    end

    fifo_mem #(
        .DEPTH  (DEPTH),
        .AWIDTH (PTRWIDTH),
        .DWIDTH (DWIDTH)
    ) u_mem (
        .clk   (wclk),
        .we    (push_ok),
        .waddr (wr_ptr_q[PTRWIDTH-1:0]),
        .wdata (wdata),
        .re    (pop_ok),
        .raddr (rd_ptr_q[PTRWIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // The storage read register has no reset, so rdata is forced to zero
    // until the first pop after reset has loaded it.
    assign rdata     = rd_seen_q ? mem_rdata : '0;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_core.sv
module tb_sync_fifo_core;

    localparam int DEPTH = 16;

    logic       wclk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] wdata = '0;
    logic       full, empty, overflow, underflow;
    logic [7:0] rdata;
    logic [4:0] count;

    typedef struct {
        logic [7:0] rdata;
        int         count;
        bit         full;
        bit         empty;
        bit         ovf;
        bit         unf;
    } rec_t;

    logic [7:0] mq[$];      // reference FIFO contents
    logic [7:0] data_q[$];  // words the consumer should see, in order
    rec_t       stat_q[$];  // expected post-edge status, one per cycle
    logic [7:0] rdm = '0;   // reference value of the rdata register
    bit         dut_fire = 1'b0;
    int         n_chk = 0;
    int         errs = 0;

    sync_fifo_core #(.DEPTH(16), .PTRWIDTH(4), .DWIDTH(8)) dut (
        .wclk      (wclk),
        .reset     (reset),
        .push      (push),
        .wdata     (wdata),
        .full      (full),
        .pop       (pop),
        .rdata     (rdata),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 wclk = ~wclk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus; the model decides acceptance from its own size.
    task automatic cycle(input bit p, input bit q, input logic [7:0] d);
        rec_t r;
        bit   acc_w, acc_r;
        push  = p;
        pop   = q;
        wdata = d;
        acc_w = p && (mq.size() < DEPTH);
        acc_r = q && (mq.size() > 0);
        r.ovf = p && (mq.size() == DEPTH);
        r.unf = q && (mq.size() == 0);
        if (acc_r) begin
            rdm = mq.pop_front();
            data_q.push_back(rdm);
        end
        if (acc_w) mq.push_back(d);
        r.rdata = rdm;
        r.count = mq.size();
        r.full  = (mq.size() == DEPTH);
        r.empty = (mq.size() == 0);
        @(posedge wclk);
        #1;
        stat_q.push_back(r);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Monitor: a DUT-accepted pop means a word is on rdata after the edge.
    always @(posedge wclk) dut_fire <= pop && !empty && !reset;

    always @(negedge wclk) begin
        rec_t       r;
        logic [7:0] exp;
        if (dut_fire) begin
            if (data_q.size() == 0) chk("unexpected_pop", 32'd1, 32'd0);
            else begin
                exp = data_q.pop_front();
                chk("rdata_seq", 32'(rdata), 32'(exp));
            end
        end
        if (stat_q.size() > 0) begin
            r = stat_q.pop_front();
            chk("rdata",     32'(rdata),     32'(r.rdata));
            chk("count",     32'(count),     32'(r.count));
            chk("full",      32'(full),      32'(r.full));
            chk("empty",     32'(empty),     32'(r.empty));
            chk("overflow",  32'(overflow),  32'(r.ovf));
            chk("underflow", 32'(underflow), 32'(r.unf));
        end
    end

    initial begin
        // Reset held for three edges.
        repeat (3) @(posedge wclk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_unf",   32'(underflow), 32'd0);
        @(negedge wclk);
        #1 reset = 1'b0;

        // Fill, then one push too many, then idle to see the pulse drop.
        for (int i = 1; i <= 16; i++) cycle(1, 0, 8'(i));
        cycle(1, 0, 8'hAA);
        cycle(0, 0, 8'h00);

        // Drain, then one pop too many; rdata must hold 0x10.
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'h00);
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);

        // Streaming at occupancy 3 across the index wrap.
        for (int i = 0; i < 3; i++) cycle(1, 0, 8'(i));
        for (int i = 3; i < 40; i++) cycle(1, 1, 8'(i));
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00);

        // Simultaneous push+pop at count 5.
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h50 + i));
        for (int i = 0; i < 4; i++) cycle(1, 1, 8'(8'h60 + i));
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'h00);

        // Simultaneous push+pop when empty, then drain the one word.
        cycle(1, 1, 8'h77);
        cycle(0, 1, 8'h00);

        // Simultaneous push+pop when full.
        for (int i = 0; i < 16; i++) cycle(1, 0, 8'(8'h80 + i));
        cycle(1, 1, 8'hEE);
        for (int i = 0; i < 15; i++) cycle(0, 1, 8'h00);

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            cycle(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 50),
                  8'($urandom));

        // Bring occupancy to exactly 9, then reset between edges.
        while (mq.size() > 0) cycle(0, 1, 8'h00);
        for (int i = 0; i < 9; i++) cycle(1, 0, 8'(8'hC0 + i));
        @(negedge wclk);
        #1 reset = 1'b1;
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_full",  32'(full),  32'd0);
        chk("arst_rdata", 32'(rdata), 32'd0);
        mq.delete();
        data_q.delete();
        rdm = '0;
        @(posedge wclk);
        @(negedge wclk);
        #1 reset = 1'b0;
        cycle(1, 0, 8'h5C);
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);

        @(negedge wclk);
        #1;
        chk("data_q_drained", 32'(data_q.size()), 32'd0);
        chk("stat_q_drained", 32'(stat_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
- Single-clock, first-in-first-out data buffer: DEPTH entries of DWIDTH bits each.
- Handshake is push/pop with full/empty status flags, plus an occupancy count.
- Sits between a producer and a consumer that share one clock domain.
- Serves as the same-clock counterpart of the team's FIFO top level, with the same data-side port names.

Parameters:
- DEPTH, 16, number of storage entries; must equal 2**PTRWIDTH.
- PTRWIDTH, 4, read/write address width in bits.
- DWIDTH, 8, data word width in bits.

Ports:
- wclk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write request; wdata is written when push=1 and full=0.
- wdata  input  DWIDTH  write data.
- full  output  1  high when count==DEPTH.
- pop  input  1  read request; accepted when pop=1 and empty=0.
- rdata  output  DWIDTH  read data, registered.
- empty  output  1  high when count==0.
- count  output  PTRWIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when push=1 while full=1.
- underflow  output  1  one-cycle pulse when pop=1 while empty=1.

Behaviour:
- Reset (asynchronous assert, removal synchronous to wclk):
  - wr_ptr and rd_ptr return to 0, count to 0.
  - empty=1, full=0, rdata=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
- Pointers:
  - wr_ptr and rd_ptr are PTRWIDTH+1 bits wide (one extra wrap bit).
  - Memory is addressed with the low PTRWIDTH bits, so pointers wrap naturally from DEPTH-1 to 0.
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal) AND (MSBs differ).
  - count = wr_ptr - rd_ptr, modulo 2**(PTRWIDTH+1).
  - All three flags/count are combinational from the registered pointers, so they are valid in the same cycle the pointers change.
- Write: on an edge with push=1 and full=0, mem[wr_ptr low bits] <= wdata and wr_ptr increments.
- Read:
  - On an edge with pop=1 and empty=0, rdata <= mem[rd_ptr low bits] and rd_ptr increments.
  - Latency is one cycle: data appears on rdata after the accepting edge.
  - rdata holds its value when no pop is accepted.
- Flags and counter are evaluated against the pre-edge state; count updates by +1, -1 or 0 per edge.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: only the push is accepted; pop is ignored and underflow pulses.
  - Full: only the pop is accepted; push is ignored and overflow pulses.
- Rejected requests leave pointers and memory untouched.
- overflow/underflow are registered; each is high for exactly the cycle after the offending edge.
- Reset asserted mid-operation: all state is discarded immediately; the FIFO reads as empty.
- No read-during-write bypass is needed: an empty FIFO never services a pop, so a word is readable no earlier than the edge after it was written.

Decomposition:
- Package fifo_pkg holds:
  - default constants DEPTH_DEF=16, PTRWIDTH_DEF=4, DWIDTH_DEF=8;
  - typedef ptr_t (PTRWIDTH+1 bits) and data_t (DWIDTH bits) at the default sizes.
- One natural sub-module, fifo_mem: a DEPTH x DWIDTH register array with one synchronous write port and one synchronous read port, no reset.
- Pointer, flag and count logic stays in sync_fifo_core.

Test Plan:
- Reset with push=pop=0 for 3 cycles -> empty=1, full=0, count=0, rdata=0.
- Push 0x01..0x10 (16 words) -> count steps 1..16, full=1 after the 16th edge; a 17th push of 0xAA gives overflow=1 for one cycle and count stays 16.
- Pop 16 words from full -> rdata sequence 0x01..0x10, each one cycle after its pop; empty=1 after the last pop; a further pop gives underflow=1 and rdata holds 0x10.
- Pointer wrap: push/pop 40 words 0x00..0x27 while keeping occupancy at 3 -> data order preserved across the index 15->0 wrap; full is never set.
- Simultaneous push+pop:
  - at count=5: count stays 5 and data order is preserved;
  - when empty: the written word is accepted, underflow pulses, count=1;
  - when full: one word is popped, overflow pulses, count=15.
- Assert reset asynchronously (between edges) while count=9 -> empty=1 and count=0 immediately; after release, a push of 0x5C then a pop returns 0x5C.
